// File: rtl/conv_sequencer.sv
// conv_sequencer: sequences one 2-D "valid" convolution over row-major input
// and filter memories. A job samples its dimensions on start, walks every
// output element, issues paired input/filter reads for each filter tap and
// accumulates the products. Each finished element is presented on a
// valid/ready port with its row/column index.
//
// Optional build macro: CONV_SAT_EN
//   defined   -> signed operands, full-width product, saturating accumulator
//                that stays clamped until the next clear
//   undefined -> wrap-around arithmetic on the low DATA_W bits
//
// Every output is a register loaded from the next-state values, so an
// output changes in the same cycle as the state it belongs to.
module conv_sequencer #(
  parameter int DATA_W = 32,
  parameter int DIM_W  = 10,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  in_rows,
  input  logic [DIM_W-1:0]  in_cols,
  input  logic [DIM_W-1:0]  flt_rows,
  input  logic [DIM_W-1:0]  flt_cols,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              in_rd_en,
  output logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_rdata,
  output logic              flt_rd_en,
  output logic [ADDR_W-1:0] flt_addr,
  input  logic [DATA_W-1:0] flt_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DIM_W-1:0]  out_row,
  output logic [DIM_W-1:0]  out_col,
  output logic              out_last
);

  localparam logic [DIM_W-1:0]  DIM_ZERO  = {DIM_W{1'b0}};
  localparam logic [DIM_W-1:0]  DIM_ONE   = {{(DIM_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_EMIT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Row-major linear address: (row + rofs) * width + (col + cofs).
  // Computed at ADDR_W so a legal 1024x1024 walk never overflows.
  function automatic logic [ADDR_W-1:0] lin_addr(
    input logic [DIM_W-1:0] row,
    input logic [DIM_W-1:0] rofs,
    input logic [DIM_W-1:0] col,
    input logic [DIM_W-1:0] cofs,
    input logic [DIM_W-1:0] width
  );
    logic [ADDR_W-1:0] rr;
    logic [ADDR_W-1:0] cc;
    logic [ADDR_W-1:0] ww;
    rr = {{(ADDR_W-DIM_W){1'b0}}, row} + {{(ADDR_W-DIM_W){1'b0}}, rofs};
    cc = {{(ADDR_W-DIM_W){1'b0}}, col} + {{(ADDR_W-DIM_W){1'b0}}, cofs};
    ww = {{(ADDR_W-DIM_W){1'b0}}, width};
    return rr * ww + cc;
  endfunction

`ifdef CONV_SAT_EN
  localparam logic signed [2*DATA_W+1:0] SAT_MAX =
    {{(DATA_W+3){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [2*DATA_W+1:0] SAT_MIN =
    {{(DATA_W+3){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Signed multiply-accumulate with clamping; returns {saturated, sum}.
  function automatic logic [DATA_W:0] sat_add(
    input logic [DATA_W-1:0] acc,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic signed [2*DATA_W-1:0] prod;
    logic signed [2*DATA_W+1:0] sum;
    prod = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    sum  = $signed({{(DATA_W+2){acc[DATA_W-1]}}, acc}) + $signed({{2{prod[2*DATA_W-1]}}, prod});
    if (sum > SAT_MAX) begin
      return {1'b1, DATA_MAX};
    end else if (sum < SAT_MIN) begin
      return {1'b1, DATA_MIN};
    end else begin
      return {1'b0, sum[DATA_W-1:0]};
    end
  endfunction
`endif

  state_t             state_r, state_s;
  logic [DIM_W-1:0]   in_rows_r, in_rows_s;
  logic [DIM_W-1:0]   in_cols_r, in_cols_s;
  logic [DIM_W-1:0]   flt_rows_r, flt_rows_s;
  logic [DIM_W-1:0]   flt_cols_r, flt_cols_s;
  logic [DIM_W-1:0]   r_r, r_s;
  logic [DIM_W-1:0]   c_r, c_s;
  logic [DIM_W-1:0]   kr_r, kr_s;
  logic [DIM_W-1:0]   kc_r, kc_s;
  logic               job_err_r, job_err_s;
  logic               acc_clr_s;
  logic [DATA_W-1:0]  acc_r, acc_s;
  logic               rd_pend_r;
`ifdef CONV_SAT_EN
  logic               sat_r, sat_s;
`endif

  logic [DIM_W-1:0]   or_max_s;
  logic [DIM_W-1:0]   oc_max_s;
  logic               cfg_bad_s;
  logic               last_cur_s;
  logic               last_nxt_s;

  logic               busy_r;
  logic               done_r;
  logic               err_r;
  logic               rd_en_r;
  logic [ADDR_W-1:0]  in_addr_r;
  logic [ADDR_W-1:0]  flt_addr_r;
  logic               out_valid_r;
  logic [DATA_W-1:0]  out_data_r;
  logic [DIM_W-1:0]   out_row_r;
  logic [DIM_W-1:0]   out_col_r;
  logic               out_last_r;

  // Highest output row/column index and last-element detection.
  assign or_max_s   = in_rows_r - flt_rows_r;
  assign oc_max_s   = in_cols_r - flt_cols_r;
  assign cfg_bad_s  = (in_rows_r == DIM_ZERO) || (in_cols_r == DIM_ZERO) ||
                      (flt_rows_r == DIM_ZERO) || (flt_cols_r == DIM_ZERO) ||
                      (flt_rows_r > in_rows_r) || (flt_cols_r > in_cols_r);
  assign last_cur_s = (r_r == or_max_s) && (c_r == oc_max_s);
  assign last_nxt_s = (r_s == or_max_s) && (c_s == oc_max_s);

  // Next-state, configuration latch and index counter stepping.
  always_comb begin
    state_s    = state_r;
    in_rows_s  = in_rows_r;
    in_cols_s  = in_cols_r;
    flt_rows_s = flt_rows_r;
    flt_cols_s = flt_cols_r;
    r_s        = r_r;
    c_s        = c_r;
    kr_s       = kr_r;
    kc_s       = kc_r;
    job_err_s  = job_err_r;
    acc_clr_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          in_rows_s  = in_rows;
          in_cols_s  = in_cols;
          flt_rows_s = flt_rows;
          flt_cols_s = flt_cols;
          job_err_s  = 1'b0;
          state_s    = ST_CHECK;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (cfg_bad_s) begin
          job_err_s = 1'b1;
          state_s   = ST_DONE;
        end else begin
          r_s       = DIM_ZERO;
          c_s       = DIM_ZERO;
          kr_s      = DIM_ZERO;
          kc_s      = DIM_ZERO;
          acc_clr_s = 1'b1;
          state_s   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (kc_r == flt_cols_r - DIM_ONE) begin
          kc_s = DIM_ZERO;
          if (kr_r == flt_rows_r - DIM_ONE) begin
            kr_s    = DIM_ZERO;
            state_s = ST_DRAIN;
          end else begin
            kr_s = kr_r + DIM_ONE;
          end
        end else begin
          kc_s = kc_r + DIM_ONE;
        end
      end
      ST_DRAIN: begin
        state_s = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (last_cur_s) begin
            state_s = ST_DONE;
          end else begin
            if (c_r == oc_max_s) begin
              c_s = DIM_ZERO;
              r_s = r_r + DIM_ONE;
            end else begin
              c_s = c_r + DIM_ONE;
            end
            kr_s      = DIM_ZERO;
            kc_s      = DIM_ZERO;
            acc_clr_s = 1'b1;
            state_s   = ST_FETCH;
          end
        end else begin
          state_s = ST_EMIT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Accumulator update: one product per cycle following a read strobe.
  always_comb begin
    acc_s = acc_r;
`ifdef CONV_SAT_EN
    sat_s = sat_r;
    if (acc_clr_s) begin
      acc_s = DATA_ZERO;
      sat_s = 1'b0;
    end else if (rd_pend_r && !sat_r) begin
      {sat_s, acc_s} = sat_add(acc_r, in_rdata, flt_rdata);
    end else begin
      acc_s = acc_r;
      sat_s = sat_r;
    end
`else
    if (acc_clr_s) begin
      acc_s = DATA_ZERO;
    end else if (rd_pend_r) begin
      acc_s = acc_r + in_rdata * flt_rdata;
    end else begin
      acc_s = acc_r;
    end
`endif
  end

  // State, configuration, counters and accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      in_rows_r  <= DIM_ZERO;
      in_cols_r  <= DIM_ZERO;
      flt_rows_r <= DIM_ZERO;
      flt_cols_r <= DIM_ZERO;
      r_r        <= DIM_ZERO;
      c_r        <= DIM_ZERO;
      kr_r       <= DIM_ZERO;
      kc_r       <= DIM_ZERO;
      job_err_r  <= 1'b0;
      acc_r      <= DATA_ZERO;
      rd_pend_r  <= 1'b0;
`ifdef CONV_SAT_EN
      sat_r      <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      in_rows_r  <= in_rows_s;
      in_cols_r  <= in_cols_s;
      flt_rows_r <= flt_rows_s;
      flt_cols_r <= flt_cols_s;
      r_r        <= r_s;
      c_r        <= c_s;
      kr_r       <= kr_s;
      kc_r       <= kc_s;
      job_err_r  <= job_err_s;
      acc_r      <= acc_s;
      rd_pend_r  <= rd_en_r;
`ifdef CONV_SAT_EN
      sat_r      <= sat_s;
`endif
    end
  end

  // Output registers loaded from next-state values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      rd_en_r     <= 1'b0;
      in_addr_r   <= ADDR_ZERO;
      flt_addr_r  <= ADDR_ZERO;
      out_valid_r <= 1'b0;
      out_data_r  <= DATA_ZERO;
      out_row_r   <= DIM_ZERO;
      out_col_r   <= DIM_ZERO;
      out_last_r  <= 1'b0;
    end else begin
      busy_r  <= (state_s == ST_CHECK) || (state_s == ST_FETCH) ||
                 (state_s == ST_DRAIN) || (state_s == ST_EMIT);
      done_r  <= (state_s == ST_DONE);
      err_r   <= (state_s == ST_DONE) && job_err_s;
      rd_en_r <= (state_s == ST_FETCH);
      if (state_s == ST_FETCH) begin
        in_addr_r  <= lin_addr(r_s, kr_s, c_s, kc_s, in_cols_r);
        flt_addr_r <= lin_addr(kr_s, DIM_ZERO, kc_s, DIM_ZERO, flt_cols_r);
      end else begin
        in_addr_r  <= ADDR_ZERO;
        flt_addr_r <= ADDR_ZERO;
      end
      if (state_s == ST_EMIT) begin
        out_valid_r <= 1'b1;
        out_data_r  <= acc_s;
        out_row_r   <= r_s;
        out_col_r   <= c_s;
        out_last_r  <= last_nxt_s;
      end else begin
        out_valid_r <= 1'b0;
        out_data_r  <= DATA_ZERO;
        out_row_r   <= DIM_ZERO;
        out_col_r   <= DIM_ZERO;
        out_last_r  <= 1'b0;
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign in_rd_en  = rd_en_r;
  assign flt_rd_en = rd_en_r;
  assign in_addr   = in_addr_r;
  assign flt_addr  = flt_addr_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_row   = out_row_r;
  assign out_col   = out_col_r;
  assign out_last  = out_last_r;

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: table of configurations, directed
// corner sequences and randomized jobs against a behavioural convolution
// model built from plain loops over the memory arrays.
module tb_conv_sequencer;
  localparam int DATA_W = 32;
  localparam int DIM_W  = 10;
  localparam int ADDR_W = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DIM_W-1:0]  in_rows, in_cols, flt_rows, flt_cols;
  logic              busy, done, err;
  logic              in_rd_en, flt_rd_en;
  logic [ADDR_W-1:0] in_addr, flt_addr;
  logic [DATA_W-1:0] in_rdata, flt_rdata;
  logic              out_valid, out_ready, out_last;
  logic [DATA_W-1:0] out_data;
  logic [DIM_W-1:0]  out_row, out_col;

  always #5 clk = ~clk;

  conv_sequencer #(.DATA_W(DATA_W), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_rows(in_rows), .in_cols(in_cols), .flt_rows(flt_rows), .flt_cols(flt_cols),
    .busy(busy), .done(done), .err(err),
    .in_rd_en(in_rd_en), .in_addr(in_addr), .in_rdata(in_rdata),
    .flt_rd_en(flt_rd_en), .flt_addr(flt_addr), .flt_rdata(flt_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last)
  );

  logic [31:0] in_mem  [0:4095];
  logic [31:0] flt_mem [0:4095];

  // Synchronous-read memories with one cycle of latency.
  always @(posedge clk) begin
    if (in_rd_en)  in_rdata  <= in_mem[in_addr[11:0]];
    if (flt_rd_en) flt_rdata <= flt_mem[flt_addr[11:0]];
  end

  typedef struct {
    logic [31:0] data;
    logic [9:0]  row;
    logic [9:0]  col;
    logic        last;
  } elem_t;

  typedef struct {
    int ir; int ic; int fr; int fc;
    bit exp_err;
    int exp_cnt;
  } cfg_vec_t;

  elem_t exp_q[$];
  elem_t got_q[$];

  int checks = 0;
  int errors = 0;

  bit job_finished, job_err, job_saw_rd, job_saw_valid, job_emit_strobe, job_unstable;
  int job_done_lat, job_first_lat, job_hs_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference convolution computed straight from the memory arrays.
  task automatic build_expect(input int ir, input int ic, input int fr, input int fc);
    exp_q.delete();
    for (int r = 0; r <= ir - fr; r++) begin
      for (int c = 0; c <= ic - fc; c++) begin
        elem_t e;
        longint acc = 0;
        bit sat = 0;
        logic [31:0] acc32 = 32'd0;
        for (int kr = 0; kr < fr; kr++) begin
          for (int kc = 0; kc < fc; kc++) begin
            logic [31:0] a, b;
            a = in_mem[(r + kr) * ic + c + kc];
            b = flt_mem[kr * fc + kc];
`ifdef CONV_SAT_EN
            if (!sat) begin
              longint s;
              s = acc + longint'($signed(a)) * longint'($signed(b));
              if (s > 64'sd2147483647) begin acc = 64'sd2147483647; sat = 1; end
              else if (s < -64'sd2147483648) begin acc = -64'sd2147483648; sat = 1; end
              else acc = s;
            end
            acc32 = acc[31:0];
`else
            acc32 = acc32 + a * b;
`endif
          end
        end
        e.data = acc32;
        e.row  = 10'(r);
        e.col  = 10'(c);
        e.last = (r == ir - fr) && (c == ic - fc);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic fill_mems(input int n_in, input int n_flt);
    for (int i = 0; i < n_in; i++)  in_mem[i]  = $urandom;
    for (int i = 0; i < n_flt; i++) flt_mem[i] = $urandom;
  endtask

  // Runs one job; observes at falling edges, drives out_ready there too.
  task automatic run_job(input int ir, input int ic, input int fr, input int fc,
                         input int ready_pct, input int bp_elem, input int glitch_cyc);
    bit prev_stall = 0;
    elem_t pe;
    int elem = 0;
    int bp_cnt = 0;
    got_q.delete();
    job_finished = 0; job_err = 0; job_saw_rd = 0; job_saw_valid = 0;
    job_emit_strobe = 0; job_unstable = 0;
    job_done_lat = -1; job_first_lat = -1; job_hs_cyc = -1;
    @(negedge clk);
    in_rows = 10'(ir); in_cols = 10'(ic); flt_rows = 10'(fr); flt_cols = 10'(fc);
    start = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    in_rows = 10'($urandom_range(1, 9)); in_cols = 10'($urandom_range(1, 9));
    flt_rows = 10'($urandom_range(0, 3)); flt_cols = 10'($urandom_range(0, 3));
    for (int cyc = 1; cyc <= 20000 && !job_finished; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc == 1) chk("busy_after_start", busy, 1);
      if (in_rd_en || flt_rd_en) job_saw_rd = 1;
      if (out_valid) begin
        job_saw_valid = 1;
        if (job_first_lat < 0) job_first_lat = cyc;
        if (in_rd_en || flt_rd_en) job_emit_strobe = 1;
      end
      if (prev_stall) begin
        if (!out_valid || out_data !== pe.data || out_row !== pe.row ||
            out_col !== pe.col || out_last !== pe.last) job_unstable = 1;
      end
      if (done) begin
        job_err = err;
        job_done_lat = cyc;
        job_finished = 1;
      end
      start = (cyc == glitch_cyc) ? 1'b1 : 1'b0;
      if (out_valid) begin
        if (elem == bp_elem && bp_cnt < 5) begin
          out_ready = 1'b0;
          bp_cnt++;
        end else begin
          out_ready = ($urandom_range(99) < ready_pct) ? 1'b1 : 1'b0;
        end
        pe.data = out_data; pe.row = out_row; pe.col = out_col; pe.last = out_last;
        if (out_ready) begin
          got_q.push_back(pe);
          job_hs_cyc = cyc;
          elem++;
        end
        prev_stall = !out_ready;
      end else begin
        out_ready = 1'($urandom_range(1));
        prev_stall = 0;
      end
    end
    start = 1'b0;
    if (!job_finished) chk("job_timeout", 0, 1);
  endtask

  task automatic check_legal(input string tag, input int fr, input int fc);
    chk({tag, "_finished"}, job_finished, 1);
    chk({tag, "_err"}, job_err, 0);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    chk({tag, "_first_lat"}, job_first_lat, 3 + fr * fc);
    chk({tag, "_done_after_hs"}, job_done_lat, job_hs_cyc + 1);
    chk({tag, "_no_strobe_in_emit"}, job_emit_strobe, 0);
    chk({tag, "_stable_stall"}, job_unstable, 0);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), got_q[i].data, exp_q[i].data);
      chk($sformatf("%s_row%0d", tag, i), got_q[i].row, exp_q[i].row);
      chk($sformatf("%s_col%0d", tag, i), got_q[i].col, exp_q[i].col);
      chk($sformatf("%s_last%0d", tag, i), got_q[i].last, exp_q[i].last);
    end
  endtask

  task automatic load_basic();
    for (int i = 0; i < 9; i++) in_mem[i] = 32'(i + 1);
    for (int i = 0; i < 4; i++) flt_mem[i] = 32'd1;
  endtask

  task automatic check_basic_consts(input string tag);
    logic [31:0] want [4];
    want[0] = 32'd12; want[1] = 32'd16; want[2] = 32'd24; want[3] = 32'd28;
    chk({tag, "_n"}, got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      chk($sformatf("%s_const%0d", tag, i), got_q[i].data, want[i]);
  endtask

  cfg_vec_t vecs [8];

  initial begin
    vecs[0] = '{3, 3, 4, 4, 1'b1, 0};
    vecs[1] = '{3, 3, 0, 2, 1'b1, 0};
    vecs[2] = '{0, 3, 1, 1, 1'b1, 0};
    vecs[3] = '{2, 3, 3, 1, 1'b1, 0};
    vecs[4] = '{3, 3, 3, 3, 1'b0, 1};
    vecs[5] = '{4, 5, 2, 3, 1'b0, 9};
    vecs[6] = '{1, 1, 1, 1, 1'b0, 1};
    vecs[7] = '{5, 2, 2, 2, 1'b0, 4};

    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    in_rows = 10'd0; in_cols = 10'd0; flt_rows = 10'd0; flt_cols = 10'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, err, in_rd_en, flt_rd_en, out_valid, out_last,
                          in_addr, flt_addr, out_data, out_row, out_col}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic 3x3 by 2x2 of ones.
    load_basic();
    build_expect(3, 3, 2, 2);
    run_job(3, 3, 2, 2, 100, -1, -1);
    check_legal("basic", 2, 2);
    check_basic_consts("basic");

    // Backpressure on the second element.
    run_job(3, 3, 2, 2, 100, 1, -1);
    check_legal("bp", 2, 2);
    check_basic_consts("bp");

    // Table of configurations.
    for (int v = 0; v < 8; v++) begin
      fill_mems(64, 64);
      run_job(vecs[v].ir, vecs[v].ic, vecs[v].fr, vecs[v].fc, 100, -1, -1);
      chk($sformatf("vec%0d_err", v), job_err, vecs[v].exp_err);
      chk($sformatf("vec%0d_count", v), got_q.size(), vecs[v].exp_cnt);
      if (vecs[v].exp_err) begin
        chk($sformatf("vec%0d_done_lat", v), job_done_lat, 2);
        chk($sformatf("vec%0d_no_rd", v), job_saw_rd, 0);
        chk($sformatf("vec%0d_no_valid", v), job_saw_valid, 0);
      end else begin
        build_expect(vecs[v].ir, vecs[v].ic, vecs[v].fr, vecs[v].fc);
        check_legal($sformatf("vec%0d", v), vecs[v].fr, vecs[v].fc);
      end
    end

    // 1x1 scale filter, with start pulsed while busy.
    in_mem[0] = 32'd5; in_mem[1] = 32'd6; in_mem[2] = 32'd7; in_mem[3] = 32'd8;
    flt_mem[0] = 32'd2;
    run_job(2, 2, 1, 1, 100, -1, 4);
    chk("scale_n", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      chk($sformatf("scale%0d", i), got_q[i].data, 32'(10 + 2 * i));
    begin
      bit extra = 0;
      repeat (12) begin
        @(negedge clk);
        if (busy || out_valid || done) extra = 1;
      end
      chk("no_second_job", extra, 0);
    end

    // Overflow behaviour of the accumulator.
    in_mem[0] = 32'h7FFFFFFF; flt_mem[0] = 32'd2;
    run_job(1, 1, 1, 1, 100, -1, -1);
`ifdef CONV_SAT_EN
    chk("ovf_pos", got_q.size() > 0 ? got_q[0].data : 32'hDEAD, 32'h7FFFFFFF);
`else
    chk("ovf_pos", got_q.size() > 0 ? got_q[0].data : 32'hDEAD, 32'hFFFFFFFE);
`endif
    in_mem[0] = 32'h80000000;
    run_job(1, 1, 1, 1, 100, -1, -1);
`ifdef CONV_SAT_EN
    chk("ovf_neg", got_q.size() > 0 ? got_q[0].data : 32'hDEAD, 32'h80000000);
`else
    chk("ovf_neg", got_q.size() > 0 ? got_q[0].data : 32'hDEAD, 32'h00000000);
`endif

    // Reset in the FETCH phase of the second element.
    load_basic();
    @(negedge clk);
    in_rows = 10'd3; in_cols = 10'd3; flt_rows = 10'd2; flt_cols = 10'd2;
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("midjob_fetching", in_rd_en, 1);
    rst = 1'b1;
    #1;
    chk("midjob_reset_outputs", {busy, done, err, in_rd_en, flt_rd_en, out_valid, out_last,
                                 in_addr, flt_addr, out_data, out_row, out_col}, 64'd0);
    begin
      bit saw_done = 0;
      repeat (3) begin
        @(negedge clk);
        if (done || err) saw_done = 1;
      end
      rst = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (done || err || busy) saw_done = 1;
      end
      chk("midjob_no_done", saw_done, 0);
    end
    build_expect(3, 3, 2, 2);
    run_job(3, 3, 2, 2, 100, -1, -1);
    check_legal("after_rst", 2, 2);
    check_basic_consts("after_rst");

    // Randomized jobs with random backpressure.
    for (int j = 0; j < 12; j++) begin
      int ir, ic, fr, fc;
      ir = $urandom_range(1, 6); ic = $urandom_range(1, 6);
      fr = $urandom_range(1, ir); fc = $urandom_range(1, ic);
      fill_mems(ir * ic, fr * fc);
      build_expect(ir, ic, fr, fc);
      run_job(ir, ic, fr, fc, 60, -1, -1);
      check_legal($sformatf("rnd%0d", j), fr, fc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
